// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for a 2-share masked Ascon permutation: owns the shared state,
// adds round constants to share A and hands one fresh random word to each round.
module ascon_perm_ctrl #(
    parameter int ROUNDS_MAX = 12,
    parameter int LANE_W     = 64,
    parameter int RAND_W     = 320
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [3:0]          nrounds_i,
    input  logic [5*LANE_W-1:0] state_a_i,
    input  logic [5*LANE_W-1:0] state_b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [5*LANE_W-1:0] state_a_o,
    output logic [5*LANE_W-1:0] state_b_o,
    input  logic                rand_valid_i,
    input  logic [RAND_W-1:0]   rand_i,
    output logic                rand_ready_o,
    output logic [5*LANE_W-1:0] dp_a_o,
    output logic [5*LANE_W-1:0] dp_b_o,
    output logic [RAND_W-1:0]   dp_rand_o,
    input  logic [5*LANE_W-1:0] dp_a_i,
    input  logic [5*LANE_W-1:0] dp_b_i
);
    // state     | meaning
    // S_IDLE    | waiting for start_i
    // S_ISSUE   | present state + constant, wait for one PRNG word
    // S_WAIT    | datapath pipeline stage 2, inputs held
    // S_CAPTURE | load round result, advance round index
    // S_DONE    | result valid, one-cycle done pulse

    localparam int          STATE_W = 5 * LANE_W;
    localparam logic [3:0]  RMAX    = 4'(ROUNDS_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         rounds_q, rounds_d;
    logic [3:0]         rnd_q, rnd_d;
    logic [STATE_W-1:0] sa_q, sa_d;
    logic [STATE_W-1:0] sb_q, sb_d;

    logic [3:0]         rc_idx;
    logic [STATE_W-1:0] rc_vec;
    logic               in_round;
    logic               xfer;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            rounds_q <= '0;
            rnd_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
        end else begin
            state_q  <= state_d;
            rounds_q <= rounds_d;
            rnd_q    <= rnd_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
        end
    end

    // Short permutations use the tail of the constant schedule: r = 12 - a + i.
    always_comb begin
        rc_idx = RMAX - rounds_q + rnd_q;
        rc_vec = '0;
        rc_vec[2*LANE_W +: 8] = {~rc_idx, rc_idx};
    end

    assign in_round = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPTURE);
    assign xfer     = (state_q == S_ISSUE) && rand_valid_i;

    always_comb begin
        state_d  = state_q;
        rounds_d = rounds_q;
        rnd_d    = rnd_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sa_d     = state_a_i;
                    sb_d     = state_b_i;
                    rnd_d    = '0;
                    rounds_d = (nrounds_i == 4'd0 || nrounds_i > RMAX) ? RMAX : nrounds_i;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (xfer) state_d = S_WAIT;
            end
            S_WAIT: state_d = S_CAPTURE;
            S_CAPTURE: begin
                sa_d    = dp_a_i;
                sb_d    = dp_b_i;
                rnd_d   = rnd_q + 4'd1;
                state_d = (rnd_q == rounds_q - 4'd1) ? S_DONE : S_ISSUE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign rand_ready_o = xfer;
    assign dp_rand_o    = xfer ? rand_i : '0;
    assign state_a_o    = sa_q;
    assign state_b_o    = sb_q;
    assign dp_a_o       = in_round ? (sa_q ^ rc_vec) : sa_q;
    assign dp_b_o       = sb_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl; a linear two-share round stand-in plays the datapath
// so the unmasked reference (A^B) can be recomputed in the bench.
module tb_ascon_perm_ctrl;
    logic         clk_i = 0;
    logic         rst_ni = 0;
    logic         start_i = 0;
    logic [3:0]   nrounds_i = '0;
    logic [319:0] state_a_i = '0, state_b_i = '0;
    logic         busy_o, done_o;
    logic [319:0] state_a_o, state_b_o;
    logic         rand_valid_i = 0;
    logic [319:0] rand_i = '0;
    logic         rand_ready_o;
    logic [319:0] dp_a_o, dp_b_o, dp_rand_o;
    logic [319:0] dp_a_i, dp_b_i;

    int vectors = 0;
    int miscompares = 0;
    int words;
    logic [7:0] consts[$];

    always #5 clk_i = ~clk_i;

    ascon_perm_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .nrounds_i(nrounds_i),
        .state_a_i(state_a_i), .state_b_i(state_b_i), .busy_o(busy_o), .done_o(done_o),
        .state_a_o(state_a_o), .state_b_o(state_b_o), .rand_valid_i(rand_valid_i),
        .rand_i(rand_i), .rand_ready_o(rand_ready_o), .dp_a_o(dp_a_o), .dp_b_o(dp_b_o),
        .dp_rand_o(dp_rand_o), .dp_a_i(dp_a_i), .dp_b_i(dp_b_i)
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] lin(input logic [319:0] s);
        logic [319:0] o;
        logic [63:0]  x;
        int r1[5] = '{19, 61, 1, 10, 7};
        int r2[5] = '{28, 39, 6, 17, 41};
        o = s;
        for (int k = 0; k < 5; k++) begin
            x = s[64*k +: 64];
            o[64*k +: 64] = x ^ ror(x, r1[k]) ^ ror(x, r2[k]);
        end
        return o;
    endfunction

    function automatic logic [7:0] exp_rc(input int a, input int i);
        logic [3:0] r;
        r = 4'(12 - a + i);
        return {~r, r};
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] x_in, input int a);
        logic [319:0] x;
        x = x_in;
        for (int i = 0; i < a; i++) begin
            x[135:128] = x[135:128] ^ exp_rc(a, i);
            x = lin(x);
        end
        return x;
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Datapath stand-in: samples at the word transfer, result ready by CAPTURE.
    logic [319:0] dpa_q = '0, dpb_q = '0;
    always @(posedge clk_i) begin
        if (rand_ready_o && rand_valid_i) begin
            dpa_q <= lin(dp_a_o) ^ dp_rand_o;
            dpb_q <= lin(dp_b_o) ^ dp_rand_o;
        end
    end
    assign dp_a_i = dpa_q;
    assign dp_b_i = dpb_q;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] nr, input logic [319:0] ia, input logic [319:0] ib,
                       input int stall_round, input int stall_len, input bit zero_rand,
                       input bit poke, input int rst_round, output int cyc);
        int since, stall_left, dones;
        logic [319:0] held;
        bit held_v;
        words = 0;
        consts.delete();
        since = 3;
        stall_left = stall_len;
        held_v = 0;
        held = '0;
        @(negedge clk_i);
        start_i = 1; nrounds_i = nr; state_a_i = ia; state_b_i = ib; rand_valid_i = 0;
        @(negedge clk_i);
        start_i = 0;
        cyc = 1;
        chk("busy_after_start", 320'(busy_o), 320'(1));
        while (!done_o && cyc < 200) begin
            since++;
            if (poke && cyc == 5) begin
                start_i = 1; nrounds_i = 4'd1; state_a_i = '1; state_b_i = '0;
            end else begin
                start_i = 0;
            end
            if (rst_round != 0 && words == rst_round && since == 1) begin
                rst_ni = 0;
                #1;
                chk("rst_busy", 320'(busy_o), '0);
                chk("rst_state_a", state_a_o, '0);
                chk("rst_dp_a", dp_a_o, '0);
                chk("rst_dp_rand", dp_rand_o, '0);
                chk("rst_ready", 320'(rand_ready_o), '0);
                @(negedge clk_i);
                @(negedge clk_i);
                rst_ni = 1;
                dones = 0;
                repeat (40) begin
                    @(negedge clk_i);
                    if (done_o) dones++;
                end
                chk("rst_no_done", 320'(dones), '0);
                cyc = -1;
                return;
            end
            if (stall_left > 0 && words == stall_round && since >= 3) begin
                rand_valid_i = 0;
                stall_left--;
                if (held_v) chk("stall_dp_a_stable", dp_a_o, held);
                else begin
                    held = dp_a_o;
                    held_v = 1;
                end
            end else begin
                rand_valid_i = 1;
            end
            rand_i = zero_rand ? '0 : rnd320();
            #1;
            if (rand_ready_o) begin
                consts.push_back(dp_a_o[135:128] ^ state_a_o[135:128]);
                words++;
                since = 0;
            end
            @(negedge clk_i);
            cyc++;
        end
        start_i = 0;
        if (!done_o) chk("done_timeout", 320'(done_o), 320'(1));
    endtask

    initial begin
        logic [319:0] a0, b0, a1, b1, r12, r6, ra_rand;
        int cyc;

        a0 = rnd320();
        b0 = rnd320();
        a1 = rnd320();
        b1 = rnd320();
        r12 = ref_perm(a0 ^ b0, 12);
        r6  = ref_perm(a1 ^ b1, 6);

        repeat (2) @(negedge clk_i);
        chk("reset_busy", 320'(busy_o), '0);
        chk("reset_done", 320'(done_o), '0);
        chk("reset_ready", 320'(rand_ready_o), '0);
        chk("reset_state_a", state_a_o, '0);
        chk("reset_state_b", state_b_o, '0);
        chk("reset_dp_rand", dp_rand_o, '0);
        rst_ni = 1;

        run(4'd12, a0, b0, -1, 0, 0, 0, 0, cyc);
        chk("a12_latency", 320'(cyc), 320'(37));
        chk("a12_busy_at_done", 320'(busy_o), 320'(1));
        chk("a12_result", state_a_o ^ state_b_o, r12);
        chk("a12_words", 320'(words), 320'(12));
        for (int i = 0; i < 12; i++)
            chk($sformatf("a12_const%0d", i), 320'(consts[i]), 320'(exp_rc(12, i)));
        ra_rand = state_a_o;
        @(negedge clk_i);
        chk("a12_busy_after", 320'(busy_o), '0);
        chk("a12_done_pulse", 320'(done_o), '0);
        repeat (3) @(negedge clk_i);
        chk("a12_hold", state_a_o ^ state_b_o, r12);

        run(4'd12, a0, b0, -1, 0, 1, 0, 0, cyc);
        chk("zero_rand_result", state_a_o ^ state_b_o, r12);
        chk("zero_rand_share_differs", 320'(state_a_o !== ra_rand), 320'(1));

        run(4'd6, a1, b1, -1, 0, 0, 0, 0, cyc);
        chk("a6_latency", 320'(cyc), 320'(19));
        chk("a6_result", state_a_o ^ state_b_o, r6);
        chk("a6_words", 320'(words), 320'(6));
        chk("a6_first_const", 320'(consts[0]), 320'(8'h96));
        chk("a6_last_const", 320'(consts[5]), 320'(8'h4b));

        run(4'd12, a0, b0, 1, 3, 0, 0, 0, cyc);
        chk("stall_latency", 320'(cyc), 320'(40));
        chk("stall_result", state_a_o ^ state_b_o, r12);
        chk("stall_words", 320'(words), 320'(12));

        run(4'd0, a0, b0, -1, 0, 0, 0, 0, cyc);
        chk("nr0_latency", 320'(cyc), 320'(37));
        chk("nr0_result", state_a_o ^ state_b_o, r12);

        run(4'd13, a0, b0, -1, 0, 0, 0, 0, cyc);
        chk("nr13_latency", 320'(cyc), 320'(37));
        chk("nr13_result", state_a_o ^ state_b_o, r12);

        run(4'd12, a0, b0, -1, 0, 0, 1, 0, cyc);
        chk("poke_latency", 320'(cyc), 320'(37));
        chk("poke_result", state_a_o ^ state_b_o, r12);

        run(4'd12, a1, b1, -1, 0, 0, 0, 5, cyc);
        chk("abort_returned", 320'(cyc), 320'(-1));
        run(4'd12, a0, b0, -1, 0, 0, 0, 0, cyc);
        chk("after_abort_latency", 320'(cyc), 320'(37));
        chk("after_abort_result", state_a_o ^ state_b_o, r12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
